alu_result_router: RTL and testbench

Steers each ALU result on a single valid/ready input to one of two buffered consumer channels: register-file writeback (WB) or memory address (MEM). It is the de-multiplexing counterpart of the operand selection in front of the ALU and sits between ALU output and the WB/LSU stages. Each channel has its own small FIFO, so a stalled consumer does not block results bound for the other.

---
 rtl/alu_result_router.sv | 163 ++++++++++++++++
 tb/tb_alu_result_router.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_router.sv
// alu_result_router: steers each accepted ALU result into a WB (data+rd) or MEM (address) FIFO.
// Optional build macro ALU_ROUTER_STATS_EN adds the wb_count/mem_count accepted-push counters.

module alu_router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rptr];

    // Guard against protocol misuse so the pointers can never run past the occupancy.
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & o_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end
endmodule

module alu_result_router #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic [4:0]        in_rd,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] mem_addr
`ifdef ALU_ROUTER_STATS_EN
    ,
    output logic [15:0]       wb_count,
    output logic [15:0]       mem_count
`endif
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never depends on ready, and in_ready depends only on in_sel and registered occupancy.
    logic              w_wb_full;
    logic              w_mem_full;
    logic              w_accept;
    logic              w_wb_push;
    logic              w_mem_push;
    logic              w_wb_pop;
    logic              w_mem_pop;
    logic [DATA_W+4:0] w_wb_out;

    // A full FIFO refuses even when it is being drained this cycle, keeping in_ready off the consumer path.
    assign in_ready   = in_sel ? ~w_mem_full : ~w_wb_full;
    assign w_accept   = in_valid & in_ready;
    assign w_wb_push  = w_accept & ~in_sel;
    assign w_mem_push = w_accept & in_sel;
    assign w_wb_pop   = wb_valid & wb_ready;
    assign w_mem_pop  = mem_valid & mem_ready;

    alu_router_fifo #(
        .WIDTH (DATA_W + 5),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_wb_push),
        .i_data  ({in_rd, in_data}),
        .i_pop   (w_wb_pop),
        .o_full  (w_wb_full),
        .o_valid (wb_valid),
        .o_data  (w_wb_out)
    );

    assign wb_rd   = w_wb_out[DATA_W+4:DATA_W];
    assign wb_data = w_wb_out[DATA_W-1:0];

    alu_router_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_mem_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_mem_push),
        .i_data  (in_data),
        .i_pop   (w_mem_pop),
        .o_full  (w_mem_full),
        .o_valid (mem_valid),
        .o_data  (mem_addr)
    );

`ifdef ALU_ROUTER_STATS_EN
    logic [15:0] r_wb_count;
    logic [15:0] r_mem_count;

    // Free-running 16-bit counters; wrap-around is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_count  <= '0;
            r_mem_count <= '0;
        end else begin
            if (w_wb_push) begin
                r_wb_count <= r_wb_count + 16'd1;
            end
            if (w_mem_push) begin
                r_mem_count <= r_mem_count + 16'd1;
            end
        end
    end

    assign wb_count  = r_wb_count;
    assign mem_count = r_mem_count;
`endif
endmodule

// File: tb/tb_alu_result_router.sv
// Testbench for alu_result_router: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.

module tb_alu_result_router;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic [4:0]        in_rd;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [4:0]        wb_rd;
    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_addr;
`ifdef ALU_ROUTER_STATS_EN
    logic [15:0]       wb_count;
    logic [15:0]       mem_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one queue per channel, entries in acceptance order.
    logic [DATA_W+4:0] wb_exp_q[$];
    logic [DATA_W-1:0] mem_exp_q[$];
    logic              m_rdy;
    logic [15:0]       m_wb_cnt;
    logic [15:0]       m_mem_cnt;

    alu_result_router #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_rd     (in_rd),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr)
`ifdef ALU_ROUTER_STATS_EN
        ,
        .wb_count  (wb_count),
        .mem_count (mem_count)
`endif
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs checked on the falling edge, then the model advances
    // by whatever transfers the coming rising edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            wb_exp_q.delete();
            mem_exp_q.delete();
            m_wb_cnt  = '0;
            m_mem_cnt = '0;
            check("rst_wb_valid", wb_valid, 1'b0);
            check("rst_mem_valid", mem_valid, 1'b0);
            check("rst_in_ready", in_ready, 1'b1);
        end else begin
            m_rdy = in_sel ? (mem_exp_q.size() < DEPTH) : (wb_exp_q.size() < DEPTH);
            check("in_ready", in_ready, m_rdy);
            check("wb_valid", wb_valid, wb_exp_q.size() != 0);
            check("mem_valid", mem_valid, mem_exp_q.size() != 0);
            if (wb_exp_q.size() != 0) begin
                check("wb_data", wb_data, wb_exp_q[0][DATA_W-1:0]);
                check("wb_rd", wb_rd, wb_exp_q[0][DATA_W+4:DATA_W]);
            end
            if (mem_exp_q.size() != 0) begin
                check("mem_addr", mem_addr, mem_exp_q[0]);
            end
`ifdef ALU_ROUTER_STATS_EN
            check("wb_count", wb_count, m_wb_cnt);
            check("mem_count", mem_count, m_mem_cnt);
`endif
            if (wb_exp_q.size() != 0 && wb_ready) void'(wb_exp_q.pop_front());
            if (mem_exp_q.size() != 0 && mem_ready) void'(mem_exp_q.pop_front());
            if (in_valid && m_rdy) begin
                if (in_sel) begin
                    mem_exp_q.push_back(in_data);
                    m_mem_cnt = m_mem_cnt + 16'd1;
                end else begin
                    wb_exp_q.push_back({in_rd, in_data});
                    m_wb_cnt = m_wb_cnt + 16'd1;
                end
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic sel, input logic [DATA_W-1:0] d, input logic [4:0] rd);
        in_valid = v;
        in_sel   = sel;
        in_data  = d;
        in_rd    = rd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        put(1'b0, 1'b0, '0, '0);
        wb_ready  = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset state
        check("reset_wb_valid", wb_valid, 1'b0);
        check("reset_mem_valid", mem_valid, 1'b0);
        check("reset_wb_data", wb_data, 32'h0);
        check("reset_wb_rd", wb_rd, 5'd0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_in_ready", in_ready, 1'b1);

        // Single WB result, one cycle latency
        put(1'b1, 1'b0, 32'h0000_00AA, 5'd5);
        wb_ready = 1'b1;
        cyc();
        put(1'b0, 1'b0, '0, '0);
        #1;
        check("first_wb_valid", wb_valid, 1'b1);
        check("first_wb_data", wb_data, 32'h0000_00AA);
        check("first_wb_rd", wb_rd, 5'd5);
        check("first_mem_valid", mem_valid, 1'b0);
        cyc();
        check("first_drained", wb_valid, 1'b0);

        // Stalled WB fills; third push refused; MEM still accepts
        wb_ready = 1'b0;
        put(1'b1, 1'b0, 32'h1, 5'd1);
        cyc();
        put(1'b1, 1'b0, 32'h2, 5'd2);
        cyc();
        put(1'b1, 1'b0, 32'h3, 5'd3);
        #1;
        check("wb_full_ready", in_ready, 1'b0);
        put(1'b1, 1'b1, 32'h8000_0000, 5'd0);
        #1;
        check("mem_ready_while_wb_full", in_ready, 1'b1);
        cyc();
        put(1'b0, 1'b0, '0, '0);
        #1;
        check("mem_valid_after_push", mem_valid, 1'b1);
        check("mem_addr_after_push", mem_addr, 32'h8000_0000);
        check("wb_stalled_head", wb_data, 32'h1);

        // Release WB: full FIFO does not accept during the popping cycle
        put(1'b1, 1'b0, 32'h3, 5'd3);
        wb_ready  = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("full_pop_no_passthru", in_ready, 1'b0);
        cyc();
        check("pop_order_2", wb_data, 32'h2);
        check("ready_after_pop", in_ready, 1'b1);
        cyc();
        put(1'b0, 1'b0, '0, '0);
        #1;
        check("pop_order_3", wb_data, 32'h3);
        check("rd_order_3", wb_rd, 5'd3);
        repeat (3) cyc();

        // Alternating stream, both consumers ready: one accept per cycle
        for (int i = 0; i < 24; i++) begin
            put(1'b1, i[0], $urandom, 5'($urandom_range(0, 31)));
            #1;
            check("stream_ready", in_ready, 1'b1);
            cyc();
        end
        put(1'b0, 1'b0, '0, '0);
        repeat (3) cyc();

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 1500; i++) begin
            put($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom,
                5'($urandom_range(0, 31)));
            wb_ready  = $urandom_range(0, 2) != 0;
            mem_ready = $urandom_range(0, 3) == 0;
            cyc();
        end
        put(1'b0, 1'b0, '0, '0);
        wb_ready  = 1'b1;
        mem_ready = 1'b1;
        repeat (4) cyc();

        // Fill both FIFOs, then reset mid-cycle
        wb_ready  = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, i[1], 32'h100 + i, 5'(i + 1));
            cyc();
        end
        put(1'b0, 1'b0, '0, '0);
        #1;
        check("prefill_wb_valid", wb_valid, 1'b1);
        check("prefill_mem_valid", mem_valid, 1'b1);
        check("prefill_wb_full", in_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_wb_valid", wb_valid, 1'b0);
        check("async_rst_mem_valid", mem_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_wb_valid", wb_valid, 1'b0);
        put(1'b1, 1'b0, 32'h55, 5'd0);
        wb_ready = 1'b1;
        cyc();
        put(1'b0, 1'b0, '0, '0);
        #1;
        check("rd0_forwarded_valid", wb_valid, 1'b1);
        check("rd0_forwarded_rd", wb_rd, 5'd0);
        check("rd0_forwarded_data", wb_data, 32'h55);
        repeat (2) cyc();

`ifdef ALU_ROUTER_STATS_EN
        // Counter wrap: 65537 WB accepts
        do_reset();
        wb_ready  = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            put(1'b1, 1'b0, 32'(i), 5'(i));
            cyc();
        end
        put(1'b0, 1'b0, '0, '0);
        #1;
        check("stats_wb_wrap", wb_count, 16'd1);
        check("stats_mem_zero", mem_count, 16'd0);
        repeat (2) cyc();
`else
        do_reset();
        check("final_reset_in_ready", in_ready, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
